// File: rtl/qspi_pkg.sv
// Shared types for the Quad-SPI transmit path: lane modes, engine states and
// per-mode helpers.
package qspi_pkg;

  localparam logic [1:0] LANE_SINGLE = 2'b00;
  localparam logic [1:0] LANE_DUAL   = 2'b01;
  localparam logic [1:0] LANE_QUAD   = 2'b10;

  localparam logic [3:0] OE_SINGLE = 4'b0001;
  localparam logic [3:0] OE_DUAL   = 4'b0011;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Mode 11 is treated as single so the datapath only ever sees three modes.
  function automatic logic [1:0] lane_norm(input logic [1:0] mode);
    return (mode == 2'b11) ? LANE_SINGLE : mode;
  endfunction

  function automatic logic [3:0] oe_mask(input logic [1:0] mode);
    case (mode)
      LANE_DUAL: return OE_DUAL;
      LANE_QUAD: return OE_QUAD;
      default:   return OE_SINGLE;
    endcase
  endfunction

  // Rise count that closes a byte, modulo 8 (single mode wraps to 0 on its 8th rise).
  function automatic logic [2:0] rises_per_byte(input logic [1:0] mode);
    case (mode)
      LANE_DUAL: return 3'd4;
      LANE_QUAD: return 3'd2;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SCK generator: low phase then high phase, each div+1 clk cycles; held low
// and cleared whenever disabled.
module qspi_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;
  logic             wrap;

  assign wrap = (cnt_q == div);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  assign sck      = sck_q;
  assign rise_stb = en && wrap && !sck_q;
  assign fall_stb = en && wrap && sck_q;

endmodule

// File: rtl/qspi_tx_engine.sv
// Quad-SPI transmit engine: pops bytes from a first-word-fall-through FIFO and
// shifts them MSB-first on 1, 2 or 4 lanes with SPI mode-0 SCK and CS_n.
module qspi_tx_engine
  import qspi_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic [1:0]       lane_mode,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic             sck,
  output logic             cs_n,
  output logic [3:0]       io_out,
  output logic [3:0]       io_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] bytes_left_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hold_cnt_q;
  logic [7:0]       sr_q;
  logic [7:0]       sr_shift;
  logic [3:0]       lanes;
  logic [2:0]       beat_q;
  logic             sent_q;
  logic             underrun_q;
  logic             rise_stb;
  logic             fall_stb;
  logic             byte_end;

  qspi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_SHIFT),
    .div      (div_q),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign byte_end = fall_stb && (beat_q == rises_per_byte(mode_q));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (xfer_len != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD:  if (!fifo_empty) state_d = ST_SHIFT;
      ST_SHIFT: if (byte_end) state_d = (bytes_left_q != '0) ? ST_LOAD : ST_HOLD;
      ST_HOLD:  if (hold_cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_shift = sr_q << 1;
    lanes    = {3'b000, sr_q[7]};
    case (mode_q)
      LANE_DUAL: begin
        sr_shift = sr_q << 2;
        lanes    = {2'b00, sr_q[7:6]};
      end
      LANE_QUAD: begin
        sr_shift = sr_q << 4;
        lanes    = sr_q[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bytes_left_q <= '0;
      mode_q       <= LANE_SINGLE;
      div_q        <= '0;
      hold_cnt_q   <= '0;
      sr_q         <= '0;
      beat_q       <= '0;
      sent_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          bytes_left_q <= xfer_len;
          mode_q       <= lane_norm(lane_mode);
          div_q        <= clk_div;
          sent_q       <= 1'b0;
          underrun_q   <= 1'b0;
        end
        ST_LOAD: if (!fifo_empty) begin
          sr_q   <= fifo_data;
          beat_q <= '0;
          sent_q <= 1'b1;
          if (bytes_left_q != '0) bytes_left_q <= bytes_left_q - LEN_W'(1);
        end else if (sent_q) begin
          underrun_q <= 1'b1;
        end
        ST_SHIFT: begin
          if (rise_stb) beat_q <= beat_q + 3'd1;
          if (fall_stb) sr_q <= sr_shift;
          if (byte_end) hold_cnt_q <= div_q;
        end
        ST_HOLD: if (hold_cnt_q != '0) hold_cnt_q <= hold_cnt_q - DIV_W'(1);
        default: ;
      endcase
    end
  end

  // Pop is gated by reset so an aborting reset cannot consume a byte.
  assign fifo_rd_en = !reset && (state_q == ST_LOAD) && !fifo_empty;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign cs_n       = !busy;
  assign done       = (state_q == ST_DONE);
  assign io_oe      = busy ? oe_mask(mode_q) : 4'b0000;
  assign io_out     = busy ? lanes : 4'b0000;
  assign underrun   = underrun_q;

endmodule
